lcd_spi_word_tx: RTL

- Consumer end of the 9-bit LCD word stream produced by the row/picture/init sequencers.
- Word format: bit8 is the D/C flag (0 = command, 1 = parameter/pixel data); bits7:0 are the payload.
- Accepts one word at a time under en_write and serialises it MSB-first onto a 4-wire SPI mode-0 LCD bus (SCL/SDA/DC/CS).
- Pulses wr_done once per transmitted byte, which is the advance strobe the sequencers count.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_spi_tick.sv | 46 ++++
 rtl/lcd_spi_word_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD word stream: the D/C flag encodings, the
// window/RAM-write command bytes the sequencers emit, the 9-bit word width
// and the state encoding of the SPI word transmitter.
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_pkg;

    // Word layout: bit 8 is D/C, bits 7:0 are the payload byte.
    localparam int LCD_WORD_W = 9;

    // D/C flag values
    localparam logic LCD_CMD = 1'b0;
    localparam logic LCD_DAT = 1'b1;

    // Command bytes used by the row/picture sequencers
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Transmitter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } lcd_tx_state_t;

endpackage

// File: rtl/lcd_spi_tick.sv
// ---------------------------------------------------------------------------
// lcd_spi_tick
// Half-period tick generator for the SPI clock. While enabled it counts
// sys_clk cycles and pulses o_tick on the last cycle of every CLK_DIV-cycle
// half period. i_restart clears the count so a new word always begins with
// a full-length low phase.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   i_restart  in   clear the half-period count (word accept)
//   i_enable   in   count while high (SHIFT state)
//   o_tick     out  high on the final cycle of a half period
// ---------------------------------------------------------------------------
module lcd_spi_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_half_cnt;

    assign o_tick = i_enable && (r_half_cnt == CNT_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_half_cnt <= '0;
        end else if (i_restart) begin
            r_half_cnt <= '0;
        end else if (i_enable) begin
            if (r_half_cnt == CNT_LAST) begin
                r_half_cnt <= '0;
            end else begin
                r_half_cnt <= r_half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_spi_word_tx.sv
// ---------------------------------------------------------------------------
// lcd_spi_word_tx
// Serialises one 9-bit LCD word {dc, byte} MSB-first onto a 4-wire SPI
// mode-0 bus and pulses wr_done once the byte has gone out. After each word
// a short GAP keeps busy high so the producer can update data before the
// next word is accepted.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   en_write   in   word request, sampled only in IDLE
//   data[8:0]  in   {dc, byte}
//   wr_done    out  one-cycle pulse per transmitted byte
//   busy       out  high from accept until the gap has elapsed
//   lcd_sclk   out  SPI clock, idles low
//   lcd_mosi   out  serial data, changes only while SCL is low
//   lcd_dc     out  D/C of the word in flight (held until next accept)
//   lcd_cs_n   out  chip select, active low
// ---------------------------------------------------------------------------
import lcd_pkg::*;

module lcd_spi_word_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  en_write,
    input  logic [LCD_WORD_W-1:0] data,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  lcd_sclk,
    output logic                  lcd_mosi,
    output logic                  lcd_dc,
    output logic                  lcd_cs_n
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    lcd_tx_state_t    r_state, w_state_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [2:0]       r_bit_cnt, w_bit_cnt_next;
    logic             r_phase, w_phase_next;     // 0 = low half, 1 = high half
    logic             r_sclk, w_sclk_next;
    logic             r_mosi, w_mosi_next;
    logic             r_dc, w_dc_next;
    logic             r_cs_n, w_cs_n_next;
    logic             r_wr_done, w_wr_done_next;
    logic             r_busy, w_busy_next;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_next;

    logic w_restart;
    logic w_tick;

    lcd_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_restart (w_restart),
        .i_enable  (r_state == ST_SHIFT),
        .o_tick    (w_tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_dc      <= LCD_CMD;
            r_cs_n    <= 1'b1;
            r_wr_done <= 1'b0;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_phase   <= w_phase_next;
            r_sclk    <= w_sclk_next;
            r_mosi    <= w_mosi_next;
            r_dc      <= w_dc_next;
            r_cs_n    <= w_cs_n_next;
            r_wr_done <= w_wr_done_next;
            r_busy    <= w_busy_next;
            r_gap_cnt <= w_gap_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_phase_next   = r_phase;
        w_sclk_next    = r_sclk;
        w_mosi_next    = r_mosi;
        w_dc_next      = r_dc;
        w_cs_n_next    = r_cs_n;
        w_wr_done_next = 1'b0;
        w_busy_next    = r_busy;
        w_gap_cnt_next = r_gap_cnt;
        w_restart      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en_write) begin
                    // MSB goes straight onto mosi so it is set up for the
                    // whole first low phase.
                    w_restart      = 1'b1;
                    w_shift_next   = data[7:0];
                    w_dc_next      = data[8];
                    w_cs_n_next    = 1'b0;
                    w_mosi_next    = data[7];
                    w_sclk_next    = 1'b0;
                    w_busy_next    = 1'b1;
                    w_bit_cnt_next = '0;
                    w_phase_next   = 1'b0;
                    w_state_next   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_phase) begin
                        w_phase_next = 1'b1;
                        w_sclk_next  = 1'b1;
                    end else if (r_bit_cnt == 3'd7) begin
                        w_phase_next = 1'b0;
                        w_sclk_next  = 1'b0;
                        w_state_next = ST_DONE;
                    end else begin
                        // Falling edge: present the next bit.
                        w_phase_next   = 1'b0;
                        w_sclk_next    = 1'b0;
                        w_mosi_next    = r_shift[6];
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end

            ST_DONE: begin
                w_wr_done_next = 1'b1;
                w_cs_n_next    = 1'b1;
                w_mosi_next    = 1'b0;
                w_gap_cnt_next = '0;
                w_state_next   = ST_GAP;
            end

            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt_next = '0;
                    w_busy_next    = 1'b0;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_done  = r_wr_done;
    assign busy     = r_busy;
    assign lcd_sclk = r_sclk;
    assign lcd_mosi = r_mosi;
    assign lcd_dc   = r_dc;
    assign lcd_cs_n = r_cs_n;

endmodule
